// File: rtl/configurations_pkg.sv
// Shared sizing constants and FSM encoding for the lane memory controller.
package configurations_pkg;
  localparam int DATA_WIDTH      = 32;
  localparam int VECTOR_LENGTH   = 1024;
  localparam int MAX_OUTSTANDING = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } mem_ctrl_state_t;
endpackage

// File: rtl/v_mem_addr_gen.sv
// Element address generator: base latched on start, stride added on every request fire.
module v_mem_addr_gen #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [31:0]      i_base,
  input  logic [31:0]      i_stride,
  input  logic             i_fire,
  output logic [31:0]      o_addr,
  output logic [CNT_W-1:0] o_issued
);
  logic [31:0]      r_addr;
  logic [31:0]      r_stride;
  logic [CNT_W-1:0] r_issued;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr   <= '0;
      r_stride <= '0;
      r_issued <= '0;
    end else if (i_start) begin
      r_addr   <= i_base;
      r_stride <= i_stride;
      r_issued <= '0;
    end else if (i_fire) begin
      // wraps modulo 2^32, so negative strides work as two's complement
      r_addr   <= r_addr + r_stride;
      r_issued <= r_issued + CNT_W'(1);
    end
  end

  assign o_addr   = r_addr;
  assign o_issued = r_issued;
endmodule

// File: rtl/v_lane_mem_ctrl.sv
// Lane memory controller: strided vector load/store sequencing between data memory and lane FIFOs.
module v_lane_mem_ctrl #(
  parameter int DATA_WIDTH      = configurations_pkg::DATA_WIDTH,
  parameter int VECTOR_LENGTH   = configurations_pkg::VECTOR_LENGTH,
  parameter int MAX_OUTSTANDING = configurations_pkg::MAX_OUTSTANDING
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cmd_valid_i,
  output logic                               cmd_ready_o,
  input  logic                               cmd_store_i,
  input  logic [31:0]                        cmd_base_addr_i,
  input  logic [31:0]                        cmd_stride_i,
  input  logic [$clog2(VECTOR_LENGTH):0]     vector_length_i,
  output logic                               mem_req_valid_o,
  input  logic                               mem_req_ready_i,
  output logic                               mem_req_we_o,
  output logic [31:0]                        mem_addr_o,
  output logic [DATA_WIDTH-1:0]              mem_wdata_o,
  input  logic                               mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]              mem_rdata_i,
  output logic                               load_fifo_we_o,
  output logic [DATA_WIDTH-1:0]              load_fifo_wdata_o,
  input  logic                               load_fifo_almostfull_i,
  output logic                               store_fifo_re_o,
  input  logic [DATA_WIDTH-1:0]              store_fifo_rdata_i,
  input  logic                               store_fifo_empty_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [1:0]                         state_o
);
  import configurations_pkg::*;

  localparam int LW = $clog2(VECTOR_LENGTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  // Handshakes (command and memory request): a transfer happens in a cycle
  // where valid and ready are both high; once valid is raised it stays high
  // with stable address/data until that transfer happens.
  mem_ctrl_state_t       r_state;
  mem_ctrl_state_t       w_next;
  logic [LW-1:0]         r_len;
  logic [LW-1:0]         r_received;
  logic [LW-1:0]         r_popped;
  logic [OW-1:0]         r_outstanding;
  logic                  r_load_hold;
  logic                  r_rd_inflight;
  logic                  r_hold_valid;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [LW-1:0]         w_issued;
  logic [31:0]           w_addr;
  logic                  w_accept;
  logic                  w_fire;
  logic                  w_load_can;

  assign w_accept   = cmd_valid_i && cmd_ready_o;
  assign w_fire     = mem_req_valid_o && mem_req_ready_i;
  assign w_load_can = (w_issued < r_len) && (r_outstanding < OW'(MAX_OUTSTANDING))
                      && !load_fifo_almostfull_i;

  v_mem_addr_gen #(.CNT_W(LW)) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_accept),
    .i_base   (cmd_base_addr_i),
    .i_stride (cmd_stride_i),
    .i_fire   (w_fire),
    .o_addr   (w_addr),
    .o_issued (w_issued)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (vector_length_i == '0) w_next = DONE;
          else if (cmd_store_i)      w_next = STORE;
          else                       w_next = LOAD;
        end
      end
      LOAD:    if (load_fifo_we_o && (r_received == r_len - LW'(1))) w_next = DONE;
      STORE:   if (w_fire && (w_issued == r_len - LW'(1)))          w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o     = 1'b0;
    busy_o          = 1'b1;
    done_o          = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_we_o    = 1'b0;
    load_fifo_we_o  = 1'b0;
    store_fifo_re_o = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      LOAD: begin
        mem_req_valid_o = r_load_hold || w_load_can;
        load_fifo_we_o  = mem_rvalid_i && (r_outstanding != '0);
      end
      STORE: begin
        mem_req_valid_o = r_hold_valid;
        mem_req_we_o    = 1'b1;
        // refill the hold register only when it is empty or draining this cycle
        store_fifo_re_o = (r_popped < r_len) && !store_fifo_empty_i && !r_rd_inflight
                          && (!r_hold_valid || mem_req_ready_i);
      end
      DONE:    done_o = 1'b1;
      default: busy_o = 1'b1;
    endcase
  end

  assign mem_addr_o        = mem_req_valid_o ? w_addr : '0;
  assign mem_wdata_o       = (mem_req_valid_o && mem_req_we_o) ? r_hold_data : '0;
  assign load_fifo_wdata_o = load_fifo_we_o ? mem_rdata_i : '0;
  assign state_o           = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len         <= '0;
      r_received    <= '0;
      r_popped      <= '0;
      r_outstanding <= '0;
      r_load_hold   <= 1'b0;
      r_rd_inflight <= 1'b0;
      r_hold_valid  <= 1'b0;
      r_hold_data   <= '0;
    end else if (w_accept) begin
      r_len         <= vector_length_i;
      r_received    <= '0;
      r_popped      <= '0;
      r_outstanding <= '0;
      r_load_hold   <= 1'b0;
      r_rd_inflight <= 1'b0;
      r_hold_valid  <= 1'b0;
    end else begin
      r_load_hold <= (r_state == LOAD) && mem_req_valid_o && !mem_req_ready_i;
      if (r_state == LOAD) begin
        if (w_fire && !load_fifo_we_o)      r_outstanding <= r_outstanding + OW'(1);
        else if (!w_fire && load_fifo_we_o) r_outstanding <= r_outstanding - OW'(1);
      end
      if (load_fifo_we_o) r_received <= r_received + LW'(1);
      r_rd_inflight <= store_fifo_re_o;
      if (store_fifo_re_o) r_popped <= r_popped + LW'(1);
      if (r_rd_inflight) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= store_fifo_rdata_i;
      end else if (w_fire && (r_state == STORE)) begin
        r_hold_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_v_lane_mem_ctrl.sv
// Bench for v_lane_mem_ctrl: directed vector table, reset-abort sequence and random commands vs a reference model.
module tb_v_lane_mem_ctrl;
  localparam int DW = 32;
  localparam int VL = 1024;
  localparam int MO = 4;
  localparam int LW = $clog2(VL) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid_i = 1'b0, cmd_ready_o, cmd_store_i = 1'b0;
  logic [31:0]   cmd_base_addr_i = '0, cmd_stride_i = '0;
  logic [LW-1:0] vector_length_i = '0;
  logic          mem_req_valid_o, mem_req_ready_i = 1'b0, mem_req_we_o;
  logic [31:0]   mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i = '0, load_fifo_wdata_o, store_fifo_rdata_i = '0;
  logic          mem_rvalid_i = 1'b0, load_fifo_we_o, load_fifo_almostfull_i = 1'b0;
  logic          store_fifo_re_o, store_fifo_empty_i = 1'b1, busy_o, done_o;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  v_lane_mem_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_store_i(cmd_store_i),
    .cmd_base_addr_i(cmd_base_addr_i), .cmd_stride_i(cmd_stride_i), .vector_length_i(vector_length_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_we_o(mem_req_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .load_fifo_we_o(load_fifo_we_o), .load_fifo_wdata_o(load_fifo_wdata_o),
    .load_fifo_almostfull_i(load_fifo_almostfull_i), .store_fifo_re_o(store_fifo_re_o),
    .store_fifo_rdata_i(store_fifo_rdata_i), .store_fifo_empty_i(store_fifo_empty_i),
    .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
  );

  typedef struct {
    bit          store;
    logic [31:0] base;
    logic [31:0] stride;
    int          len;
    int          rdy_mode;   // 0 always ready, 1 stall window, 2 random
    int          stall_s;
    int          stall_n;
    int          af_s;
    int          af_e;
    int          extra;      // extra store FIFO words beyond len
    int          af_pct;
    int          empty_pct;
    int          lat_min;
    int          lat_max;
    int          exp_reqs;   // -1 = not checked
    logic [31:0] exp_last;
    int          exp_first;
    int          exp_span;
  } vec_t;

  int n_checks = 0, n_err = 0;
  logic [31:0] salt;

  // environment knobs
  bit          drv_reset = 1'b0, drv_cmd_valid = 1'b0, drv_store = 1'b0, stray_pulse = 1'b0;
  logic [31:0] drv_base = '0, drv_stride = '0;
  int          drv_len = 0;
  int          rdy_mode, stall_s, stall_n, af_s, af_e, af_pct, empty_pct, lat_min = 1, lat_max = 1;

  // memory and FIFO models
  logic [31:0] resp_data_q[$];
  int          resp_due_q[$];
  int          last_due = 0;
  logic [DW-1:0] sf_q[$];
  logic [DW-1:0] sf_rdata_r = '0;

  // observation
  int          cyc = 0, acc_cyc = 0;
  bit          accepted;
  logic [31:0] fire_addr_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fire_data_q[$], push_q[$];
  int rd_fires, resp_cnt, re_cnt, done_cnt, done_cyc, first_valid_cyc, first_fire_cyc, last_fire_cyc;
  int last_push_cyc, max_out, stab_err, af_viol, busy_err, push_no_rv;
  bit          p_hold, p_we;
  logic [31:0] p_addr;
  logic [DW-1:0] p_wdata;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ salt;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_mon();
    fire_addr_q.delete(); fire_data_q.delete(); push_q.delete(); exp_q.delete();
    rd_fires = 0; resp_cnt = 0; re_cnt = 0; done_cnt = 0; done_cyc = 0;
    first_valid_cyc = -1; first_fire_cyc = -1; last_fire_cyc = 0; last_push_cyc = 0;
    max_out = 0; stab_err = 0; af_viol = 0; busy_err = 0; push_no_rv = 0;
    p_hold = 1'b0; accepted = 1'b0;
  endtask

  task automatic step();
    int  rel, lat, due;
    bit  af_now;
    @(negedge clk);
    cyc++;
    rel = accepted ? cyc - acc_cyc : -1;
    reset           = drv_reset;
    cmd_valid_i     = drv_cmd_valid;
    cmd_store_i     = drv_store;
    cmd_base_addr_i = drv_base;
    cmd_stride_i    = drv_stride;
    vector_length_i = LW'(drv_len);
    case (rdy_mode)
      1:       mem_req_ready_i = !(rel >= stall_s && rel < stall_s + stall_n);
      2:       mem_req_ready_i = ($urandom_range(0, 99) < 75);
      default: mem_req_ready_i = 1'b1;
    endcase
    af_now = (rel >= af_s && rel <= af_e) || ($urandom_range(0, 99) < af_pct);
    load_fifo_almostfull_i = af_now;
    if (resp_due_q.size() > 0 && resp_due_q[0] <= cyc) begin
      due          = resp_due_q.pop_front();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = resp_data_q.pop_front();
      resp_cnt++;
    end else if (stray_pulse) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEAD_BEEF;
      stray_pulse  = 1'b0;
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
    end
    store_fifo_empty_i = (sf_q.size() == 0) || ($urandom_range(0, 99) < empty_pct);
    store_fifo_rdata_i = sf_rdata_r;
    #1;
    if (reset) begin
      if (cmd_valid_i && cmd_ready_o) begin
        accepted = 1'b1;
        acc_cyc  = cyc;
      end
      if (p_hold && (!mem_req_valid_o || mem_addr_o !== p_addr || mem_wdata_o !== p_wdata
                     || mem_req_we_o !== p_we)) stab_err++;
      if (accepted && cyc > acc_cyc && done_cnt == 0 && (!busy_o || cmd_ready_o)) busy_err++;
      if (mem_req_valid_o) begin
        if (accepted && first_valid_cyc < 0) first_valid_cyc = cyc - acc_cyc;
        if (!mem_req_we_o && af_now && !p_hold) af_viol++;
      end
      if (mem_req_valid_o && mem_req_ready_i) begin
        fire_addr_q.push_back(mem_addr_o);
        if (first_fire_cyc < 0) first_fire_cyc = cyc;
        last_fire_cyc = cyc;
        if (mem_req_we_o) fire_data_q.push_back(mem_wdata_o);
        else begin
          rd_fires++;
          lat = $urandom_range(lat_min, lat_max);
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          resp_due_q.push_back(due);
          resp_data_q.push_back(mem_word(mem_addr_o));
        end
      end
      if (load_fifo_we_o) begin
        push_q.push_back(load_fifo_wdata_o);
        last_push_cyc = cyc;
        if (!mem_rvalid_i) push_no_rv++;
      end
      if (store_fifo_re_o) begin
        re_cnt++;
        if (sf_q.size() > 0) sf_rdata_r = sf_q.pop_front();
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rd_fires - resp_cnt > max_out) max_out = rd_fires - resp_cnt;
      p_hold  = mem_req_valid_o && !mem_req_ready_i;
      p_addr  = mem_addr_o;
      p_wdata = mem_wdata_o;
      p_we    = mem_req_we_o;
    end else begin
      p_hold = 1'b0;
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int          guard, ref_cyc;
    logic [31:0] ea;
    logic [DW-1:0] w;
    clear_mon();
    rdy_mode = v.rdy_mode; stall_s = v.stall_s; stall_n = v.stall_n;
    af_s = v.af_s; af_e = v.af_e; af_pct = v.af_pct; empty_pct = v.empty_pct;
    lat_min = v.lat_min; lat_max = v.lat_max;
    sf_q.delete();
    if (v.store) begin
      for (int i = 0; i < v.len + v.extra; i++) begin
        w = $urandom;
        sf_q.push_back(w);
        if (i < v.len) exp_q.push_back(w);
      end
    end
    drv_store = v.store; drv_base = v.base; drv_stride = v.stride; drv_len = v.len;
    drv_cmd_valid = 1'b1;
    guard = 0;
    while (!accepted && guard < 20) begin
      step();
      guard++;
    end
    drv_cmd_valid = 1'b0;
    // fields wander while busy; the controller must ignore them
    drv_store = $urandom_range(0, 1); drv_base = $urandom; drv_stride = $urandom;
    drv_len = $urandom_range(0, 50);
    chk("cmd_accepted", 32'(accepted), 1);
    guard = 0;
    while (done_cnt == 0 && guard < 4000) begin
      step();
      guard++;
    end
    step();
    stray_pulse = 1'b1;
    repeat (3) step();

    chk("req_count", fire_addr_q.size(), v.len);
    if (v.exp_reqs >= 0) chk("table_req_count", fire_addr_q.size(), v.exp_reqs);
    for (int i = 0; i < fire_addr_q.size() && i < v.len; i++) begin
      ea = v.base + v.stride * 32'(i);
      chk("req_addr", fire_addr_q[i], ea);
    end
    if (v.exp_reqs > 0 && fire_addr_q.size() > 0) chk("last_addr", fire_addr_q[$], v.exp_last);
    if (v.store) begin
      chk("store_re_count", re_cnt, v.len);
      chk("write_count", fire_data_q.size(), v.len);
      for (int i = 0; i < fire_data_q.size() && i < exp_q.size(); i++)
        chk("write_data", fire_data_q[i], exp_q[i]);
      chk("store_no_push", push_q.size(), 0);
    end else begin
      chk("load_push_count", push_q.size(), v.len);
      for (int i = 0; i < push_q.size() && i < v.len; i++) begin
        ea = v.base + v.stride * 32'(i);
        chk("load_data", push_q[i], mem_word(ea));
      end
      chk("load_no_re", re_cnt, 0);
      chk("load_no_write", fire_data_q.size(), 0);
      chk("push_without_rvalid", push_no_rv, 0);
    end
    chk("done_count", done_cnt, 1);
    ref_cyc = (v.len == 0) ? acc_cyc : (v.store ? last_fire_cyc : last_push_cyc);
    if (done_cnt > 0) chk("done_latency", done_cyc - ref_cyc, 1);
    if (v.exp_first >= 0) chk("first_req_latency", first_valid_cyc, v.exp_first);
    if (v.exp_span >= 0) chk("req_span", last_fire_cyc - first_fire_cyc, v.exp_span);
    chk("max_outstanding_ok", 32'(max_out <= MO), 1);
    chk("almostfull_respected", af_viol, 0);
    chk("req_stable_while_stalled", stab_err, 0);
    chk("busy_while_active", busy_err, 0);
    chk("idle_cmd_ready", 32'(cmd_ready_o), 1);
    chk("idle_busy", 32'(busy_o), 0);
    sf_q.delete();
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    int guard;
    salt = $urandom;
    tbl[0] = '{0, 32'h100, 32'd4, 8, 0, 0, 0, 0, -1, 0, 0, 0, 1, 1, 8, 32'h11C, 1, 7};
    tbl[1] = '{0, 32'h100, 32'd4, 8, 0, 0, 0, 3, 10, 0, 0, 0, 1, 1, 8, 32'h11C, 1, -1};
    tbl[2] = '{1, 32'h2000, 32'hFFFF_FFFC, 4, 0, 0, 0, 0, -1, 0, 0, 0, 1, 1, 4, 32'h1FF4, 3, 6};
    tbl[3] = '{1, 32'h3000, 32'd8, 6, 1, 6, 5, 0, -1, 2, 0, 0, 1, 1, 6, 32'h3028, 3, -1};
    tbl[4] = '{0, 32'h0, 32'd4, 0, 0, 0, 0, 0, -1, 0, 0, 0, 1, 1, 0, 32'h0, -1, -1};
    tbl[5] = '{1, 32'h80, 32'd4, 0, 0, 0, 0, 0, -1, 2, 0, 0, 1, 1, 0, 32'h0, -1, -1};
    tbl[6] = '{0, 32'hFFFF_FFF0, 32'h10, 3, 0, 0, 0, 0, -1, 0, 0, 0, 1, 1, 3, 32'h10, 1, 2};
    tbl[7] = '{0, 32'h400, 32'd4, 5, 1, 2, 3, 0, -1, 0, 0, 0, 1, 1, 5, 32'h410, 1, -1};
    tbl[8] = '{0, 32'h40, 32'd4, VL, 0, 0, 0, 0, -1, 0, 0, 0, 1, 1, VL, 32'h103C, 1, VL - 1};

    clear_mon();
    rdy_mode = 0; af_s = 0; af_e = -1; af_pct = 0; empty_pct = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_cmd_ready", 32'(cmd_ready_o), 1);
    chk("reset_busy", 32'(busy_o), 0);
    chk("reset_done", 32'(done_o), 0);
    chk("reset_req_valid", 32'(mem_req_valid_o), 0);
    chk("reset_req_we", 32'(mem_req_we_o), 0);
    chk("reset_addr", mem_addr_o, 0);
    chk("reset_load_we", 32'(load_fifo_we_o), 0);
    chk("reset_store_re", 32'(store_fifo_re_o), 0);
    drv_reset = 1'b1;
    repeat (2) step();

    for (int t = 0; t < 9; t++) run_cmd(tbl[t]);

    // reset mid-load with two reads in flight; their late responses must be dropped
    clear_mon();
    rdy_mode = 0; af_s = 0; af_e = -1; af_pct = 0; empty_pct = 0; lat_min = 12; lat_max = 12;
    drv_store = 1'b0; drv_base = 32'h500; drv_stride = 32'd4; drv_len = 8; drv_cmd_valid = 1'b1;
    guard = 0;
    while (!accepted && guard < 20) begin step(); guard++; end
    drv_cmd_valid = 1'b0;
    guard = 0;
    while (rd_fires < 2 && guard < 20) begin step(); guard++; end
    chk("rst_reads_in_flight", rd_fires, 2);
    drv_reset = 1'b0;
    repeat (2) step();
    drv_reset = 1'b1;
    repeat (16) step();
    chk("rst_responses_delivered", resp_cnt, 2);
    chk("rst_no_push", push_q.size(), 0);
    chk("rst_cmd_ready", 32'(cmd_ready_o), 1);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_no_done", done_cnt, 0);
    chk("rst_no_new_req", rd_fires, 2);

    for (int n = 0; n < 30; n++) begin
      rv.store = $urandom_range(0, 1);
      rv.base  = $urandom & 32'hFFFF_FFFC;
      case ($urandom_range(0, 3))
        0:       rv.stride = 32'd4;
        1:       rv.stride = 32'hFFFF_FFFC;
        2:       rv.stride = 32'd8;
        default: rv.stride = $urandom;
      endcase
      rv.len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
      rv.rdy_mode = 2; rv.stall_s = 0; rv.stall_n = 0; rv.af_s = 0; rv.af_e = -1;
      rv.extra = $urandom_range(0, 2); rv.af_pct = 15; rv.empty_pct = 20;
      rv.lat_min = 1; rv.lat_max = 3;
      rv.exp_reqs = -1; rv.exp_last = '0; rv.exp_first = -1; rv.exp_span = -1;
      run_cmd(rv);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
